// File: rtl/jtframe_edge_ff_if.sv
// rtl/jtframe_edge_ff_if.sv - trigger/clear/set inputs and flag outputs of the jtframe_edge_ff bank
interface jtframe_edge_ff_if #(
  parameter int W = 1
);
  logic         cen;
  logic [W-1:0] sigedge;
  logic [W-1:0] din;
  logic [W-1:0] clr;
  logic [W-1:0] set;
  logic [W-1:0] q;
  logic [W-1:0] qn;

  modport master (
    output cen, sigedge, din, clr, set,
    input  q, qn
  );

  modport slave (
    input  cen, sigedge, din, clr, set,
    output q, qn
  );
endinterface

// File: rtl/jtframe_edge_ff.sv
// rtl/jtframe_edge_ff.sv - bank of W edge-triggered flags with synchronous clear/set (6809 interrupt latch)
// Define JTFRAME_EDGE_FF_SYNC_EN to pass sigedge through a 2-flop synchronizer before edge detection.
module jtframe_edge_ff #(
  parameter int W = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  jtframe_edge_ff_if.slave   bus
);

  logic [W-1:0] sig_w;
  logic [W-1:0] edge_w;
  logic [W-1:0] last_q;
  logic [W-1:0] q_q, q_d;
  logic [W-1:0] qn_q, qn_d;

`ifdef JTFRAME_EDGE_FF_SYNC_EN
  logic [W-1:0] sync1_q;
  logic [W-1:0] sync2_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= bus.sigedge;
      sync2_q <= sync1_q;
    end
  end

  assign sig_w = sync2_q;
`else
  assign sig_w = bus.sigedge;
`endif

  assign edge_w = sig_w & ~last_q;

  // clr beats set beats edge; cen only gates the flag, never the edge history
  always_comb begin
    q_d = q_q;
    if (bus.cen) begin
      for (int i = 0; i < W; i++) begin
        if (bus.clr[i])
          q_d[i] = 1'b0;
        else if (bus.set[i])
          q_d[i] = 1'b1;
        else if (edge_w[i])
          q_d[i] = bus.din[i];
      end
    end
    qn_d = ~q_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= '0;
      q_q    <= '0;
      qn_q   <= '1;
    end else begin
      last_q <= sig_w;
      q_q    <= q_d;
      qn_q   <= qn_d;
    end
  end

  assign bus.q  = q_q;
  assign bus.qn = qn_q;

endmodule

// File: tb/tb_jtframe_edge_ff.sv
// tb/tb_jtframe_edge_ff.sv - scoreboard bench for jtframe_edge_ff with a per-bit flag reference model
module tb_jtframe_edge_ff;

  localparam int W = 3;
  localparam logic [W-1:0] ONES = '1;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  bit   clk_en = 1'b0;

  int vectors = 0;
  int miscompares = 0;

  logic [W-1:0] sb[$];
  logic [W-1:0] m_q;
  logic [W-1:0] m_last;
  logic [W-1:0] m_hist[2];

  jtframe_edge_ff_if #(.W(W)) bus ();

  jtframe_edge_ff #(.W(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always begin
    #5;
    if (clk_en) clk = ~clk;
  end

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q       = '0;
    m_last    = '0;
    m_hist[0] = '0;
    m_hist[1] = '0;
  endtask

  // Apply one cycle of inputs and predict the flags after the coming posedge
  task automatic drive(input bit c, input logic [W-1:0] s, input logic [W-1:0] d,
                       input logic [W-1:0] cl, input logic [W-1:0] st);
    logic [W-1:0] eff;
    bit rose;
    @(negedge clk);
    bus.cen     = c;
    bus.sigedge = s;
    bus.din     = d;
    bus.clr     = cl;
    bus.set     = st;
`ifdef JTFRAME_EDGE_FF_SYNC_EN
    eff       = m_hist[1];
    m_hist[1] = m_hist[0];
    m_hist[0] = s;
`else
    eff = s;
`endif
    for (int i = 0; i < W; i++) begin
      rose = (eff[i] == 1'b1) && (m_last[i] == 1'b0);
      if (c) begin
        if (cl[i])      m_q[i] = 1'b0;
        else if (st[i]) m_q[i] = 1'b1;
        else if (rose)  m_q[i] = d[i];
      end
    end
    m_last = eff;
    sb.push_back(m_q);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("midrst_q", bus.q, '0);
    check("midrst_qn", bus.qn, ONES);
    model_reset();
    @(posedge clk);
    #3 rst_n = 1'b1;
  endtask

  initial begin : monitor
    logic [W-1:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("q", bus.q, e);
        check("qn", bus.qn, ~e);
      end
    end
  end

  initial begin : stim
    bus.cen     = 1'b1;
    bus.sigedge = '0;
    bus.din     = '0;
    bus.clr     = '0;
    bus.set     = '0;
    model_reset();

    // reset with the clock stopped must act at once
    #2 rst_n = 1'b0;
    #1;
    check("rst_q", bus.q, '0);
    check("rst_qn", bus.qn, ONES);
    clk_en = 1'b1;
    @(posedge clk);
    #3 rst_n = 1'b1;
    repeat (3) drive(1'b1, '0, ONES, '0, '0);

    // edge load and no retrigger while held high
    drive(1'b1, 3'b100, ONES, '0, '0);
    repeat (10) drive(1'b1, 3'b100, ONES, '0, '0);
    drive(1'b1, 3'b100, ONES, 3'b100, '0);
    repeat (4) drive(1'b1, 3'b100, ONES, '0, '0);
    drive(1'b1, 3'b000, ONES, '0, '0);

    // priority on bit 0
    drive(1'b1, 3'b001, 3'b001, 3'b001, 3'b001);
    drive(1'b1, 3'b000, 3'b000, '0, '0);
    drive(1'b1, 3'b001, 3'b000, '0, 3'b001);
    drive(1'b1, 3'b001, 3'b000, '0, '0);

    // cen gating loses the edge
    do_reset();
    drive(1'b0, 3'b001, ONES, '0, '0);
    drive(1'b0, 3'b001, ONES, '0, '0);
    repeat (4) drive(1'b1, 3'b001, ONES, '0, '0);
    drive(1'b1, 3'b000, ONES, '0, '0);
    repeat (4) drive(1'b1, 3'b001, ONES, '0, '0);

    // interrupt latch usage
    do_reset();
    drive(1'b1, 3'b100, ONES, '0, '0);
    drive(1'b1, 3'b110, ONES, '0, '0);
    drive(1'b1, 3'b111, ONES, '0, '0);
    repeat (3) drive(1'b1, 3'b111, ONES, '0, '0);
    drive(1'b1, 3'b111, ONES, 3'b010, '0);
    repeat (3) drive(1'b1, 3'b111, ONES, '0, '0);

    // sigedge high at reset release counts as an edge
    do_reset();
    repeat (4) drive(1'b1, ONES, ONES, '0, '0);

    // randomized traffic with sparse clr/set and occasional mid-run reset
    for (int n = 0; n < 1500; n++) begin
      if (n % 300 == 299) do_reset();
      drive($urandom_range(0, 3) != 0,
            W'($urandom), W'($urandom),
            W'($urandom & $urandom & $urandom),
            W'($urandom & $urandom & $urandom));
    end

    repeat (3) @(posedge clk);
    #2;
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL drain: got %0d pending expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
